bcd_display_seq: RTL



---
 rtl/display_pkg.sv | 28 ++
 rtl/bcd7seg_lut.sv | 18 +
 rtl/bcd_display_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared segment constants, power-of-ten helper and FSM state type
// for the sequential BCD 7-segment display driver.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low a..g patterns; entry d sits at bits [7d+6:7d]
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StUpdate
  } state_e;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd7seg_lut.sv
// One BCD digit to active-low 7-segment pattern; out-of-range nibbles
// and blanked digits both show all segments off.
module bcd7seg_lut
  import display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank && (i_digit <= 4'd9)) begin
      o_seg = SEG_DIGIT[i_digit];
    end
  end

endmodule

// File: rtl/bcd_display_seq.sv
// Sequential binary-to-BCD (double-dabble, one bit per clock) with registered
// 7-segment outputs, leading-zero blanking and overflow dashes.
module bcd_display_seq
  import display_pkg::*;
#(
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned DIGITS   = 6,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7*DIGITS-1:0] hex
);

  // ceil(WIDTH*log10(2)) + 1 decimal digits are enough for any WIDTH-bit input
  localparam int unsigned LogDigits = (WIDTH * 30103 + 99999) / 100000 + 1;
  localparam int unsigned AccDigits = (DIGITS > LogDigits) ? DIGITS : LogDigits;
  localparam int unsigned AccW      = 4 * AccDigits;
  localparam int unsigned CntW      = $clog2(WIDTH + 1);
  localparam logic [63:0] OvfLimit  = pow10(DIGITS) - 64'd1;

  state_e              r_state, w_state_next;
  logic [WIDTH-1:0]    r_sreg;
  logic [AccW-1:0]     r_acc, w_acc_adj, w_acc_shift;
  logic [CntW-1:0]     r_cnt;
  logic                r_ovf_pend, r_ovf, r_done;
  logic [4*DIGITS-1:0] r_bcd;
  logic [7*DIGITS-1:0] r_hex, w_seg, w_hex_next;
  logic [DIGITS-1:0]   w_blank;
  logic                w_ovf_in;

  assign w_ovf_in = (64'(value) > OvfLimit);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (in_valid) w_state_next = StShift;
      StShift:  if (r_cnt == CntW'(1)) w_state_next = StUpdate;
      StUpdate: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_acc_adj = r_acc;
    for (int i = 0; i < int'(AccDigits); i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
    w_acc_shift = (w_acc_adj << 1) | AccW'(r_sreg[WIDTH-1]);
  end

  // Digit k (k>0) blanks only when it and every digit above it are zero
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    w_blank    = '0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_above = zero_above && (r_acc[4*k +: 4] == 4'd0);
      w_blank[k] = BLANK_LZ && zero_above;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd7seg_lut u_lut (
      .i_digit (r_acc[4*k +: 4]),
      .i_blank (w_blank[k]),
      .o_seg   (w_seg[7*k +: 7])
    );
  end

  assign w_hex_next = r_ovf_pend ? {DIGITS{SEG_DASH}} : w_seg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_sreg     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_hex      <= {DIGITS{SEG_BLANK}};
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_sreg     <= value;
            r_acc      <= '0;
            r_cnt      <= CntW'(WIDTH);
            r_ovf_pend <= w_ovf_in;
          end
        end
        StShift: begin
          r_acc  <= w_acc_shift;
          r_sreg <= r_sreg << 1;
          r_cnt  <= r_cnt - CntW'(1);
        end
        StUpdate: begin
          r_bcd  <= r_acc[4*DIGITS-1:0];
          r_hex  <= w_hex_next;
          r_ovf  <= r_ovf_pend;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != StIdle);
  assign done     = r_done;
  assign overflow = r_ovf;
  assign bcd      = r_bcd;
  assign hex      = r_hex;

endmodule
